// File: rtl/wave_sequencer_pkg.sv
// Shared constants and types for the wave sequencer: state encoding,
// Q0.7 sample landmarks and default configuration widths.
package wave_sequencer_pkg;

  localparam int N_FRAC_DEF     = 7;
  localparam int PRESCALE_W_DEF = 16;
  localparam int BURST_W_DEF    = 8;
  localparam int SAMPLE_W_DEF   = N_FRAC_DEF + 1;

  localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MIN       = 8'h80;
  localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_ONE       = 8'h7F;
  localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MINUS_ONE = 8'h81;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } seq_state_t;

endpackage

// File: rtl/wave_sequencer_strobe_prescaler.sv
// Reloadable down-counter that emits a tick whenever it reaches zero while enabled.
module wave_sequencer_strobe_prescaler #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] reload,
  output logic         tick
);

  logic [W-1:0] cnt_reg;

  assign tick = enable && (cnt_reg == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= reload;
    end else if (enable) begin
      if (cnt_reg == '0) cnt_reg <= reload;
      else               cnt_reg <= cnt_reg - W'(1);
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Sequencing controller: paced sawtooth phase counter with double-buffered
// configuration that only changes at period boundaries.
module wave_sequencer
  import wave_sequencer_pkg::*;
#(
  parameter int N_FRAC     = N_FRAC_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BURST_W    = BURST_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [PRESCALE_W-1:0] cfg_prescale_i,
  input  logic [N_FRAC-1:0]     cfg_increment_i,
  input  logic [N_FRAC:0]       cfg_threshold_i,
  input  logic [BURST_W-1:0]    cfg_burst_len_i,
  output logic [N_FRAC:0]       counter_value_o,
  output logic                  counter_value_valid_strobe_o,
  output logic [N_FRAC:0]       threshold_o,
  output logic                  period_wrap_strobe_o,
  output logic                  done_strobe_o,
  output logic                  busy_o
);

  localparam int SW = N_FRAC + 1;
  localparam logic [SW-1:0] START_VAL = {1'b1, {N_FRAC{1'b0}}};

  seq_state_t state_reg, state_next;

  logic [PRESCALE_W-1:0] act_prescale_reg, pend_prescale_reg;
  logic [N_FRAC-1:0]     act_inc_reg, pend_inc_reg;
  logic [SW-1:0]         act_thr_reg, pend_thr_reg;
  logic [BURST_W-1:0]    act_burst_reg, pend_burst_reg;
  logic                  pend_valid_reg;

  logic [SW-1:0]      counter_reg;
  logic [BURST_W-1:0] period_cnt_reg;
  logic               strobe_reg, wrap_reg, done_reg;

  logic               tick, wrap, burst_end, go_start, cfg_fire;
  logic [SW-1:0]      counter_sum;
  logic [BURST_W-1:0] period_inc;

  wave_sequencer_strobe_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (go_start),
    .enable (state_reg != ST_IDLE),
    .reload (act_prescale_reg),
    .tick   (tick)
  );

  assign cfg_fire    = cfg_valid_i && !pend_valid_reg;
  assign counter_sum = counter_reg + {1'b0, act_inc_reg};
  // A period ends when the phase crosses from the top half back to the most negative value.
  assign wrap        = tick && !counter_reg[SW-1] && counter_sum[SW-1];
  assign period_inc  = period_cnt_reg + BURST_W'(1);
  assign burst_end   = (act_burst_reg != '0) && (period_inc == act_burst_reg);

  always_comb begin
    state_next = state_reg;
    go_start   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_RUN;
          go_start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (wrap && burst_end) state_next = ST_IDLE;
        else if (stop_i)       state_next = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (wrap) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      counter_reg    <= '0;
      period_cnt_reg <= '0;
      strobe_reg     <= 1'b0;
      wrap_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= tick;
      wrap_reg   <= wrap;
      // Done trails the final wrap strobe by one cycle.
      done_reg   <= wrap_reg && (state_reg == ST_IDLE);
      if (go_start) begin
        counter_reg    <= START_VAL;
        period_cnt_reg <= '0;
      end else if (tick) begin
        counter_reg <= counter_sum;
        if (wrap && (period_cnt_reg != '1)) period_cnt_reg <= period_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_prescale_reg  <= '0;
      act_inc_reg       <= N_FRAC'(1);
      act_thr_reg       <= '0;
      act_burst_reg     <= '0;
      pend_valid_reg    <= 1'b0;
      pend_prescale_reg <= '0;
      pend_inc_reg      <= '0;
      pend_thr_reg      <= '0;
      pend_burst_reg    <= '0;
    end else begin
      if (cfg_fire && (state_reg == ST_IDLE)) begin
        act_prescale_reg <= cfg_prescale_i;
        act_inc_reg      <= cfg_increment_i;
        act_thr_reg      <= cfg_threshold_i;
        act_burst_reg    <= cfg_burst_len_i;
      end else if (cfg_fire) begin
        pend_valid_reg    <= 1'b1;
        pend_prescale_reg <= cfg_prescale_i;
        pend_inc_reg      <= cfg_increment_i;
        pend_thr_reg      <= cfg_threshold_i;
        pend_burst_reg    <= cfg_burst_len_i;
      end
      if (wrap && pend_valid_reg) begin
        act_prescale_reg <= pend_prescale_reg;
        act_inc_reg      <= pend_inc_reg;
        act_thr_reg      <= pend_thr_reg;
        act_burst_reg    <= pend_burst_reg;
        pend_valid_reg   <= 1'b0;
      end
    end
  end

  assign cfg_ready_o                  = !pend_valid_reg;
  assign counter_value_o              = counter_reg;
  assign counter_value_valid_strobe_o = strobe_reg;
  assign threshold_o                  = act_thr_reg;
  assign period_wrap_strobe_o         = wrap_reg;
  assign done_strobe_o                = done_reg;
  assign busy_o                       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: a tick-level reference model fills
// expectation queues, a negedge monitor pops and compares every strobe.
module tb_wave_sequencer;
  import wave_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, start_i, stop_i, cfg_valid_i, cfg_ready_o;
  logic [15:0] cfg_prescale_i;
  logic [6:0]  cfg_increment_i;
  logic [7:0]  cfg_threshold_i, cfg_burst_len_i;
  logic [7:0]  counter_value_o, threshold_o;
  logic        counter_value_valid_strobe_o, period_wrap_strobe_o, done_strobe_o, busy_o;

  wave_sequencer dut (
    .clk_i                        (clk),
    .rst_i                        (rst_i),
    .start_i                      (start_i),
    .stop_i                       (stop_i),
    .cfg_valid_i                  (cfg_valid_i),
    .cfg_ready_o                  (cfg_ready_o),
    .cfg_prescale_i               (cfg_prescale_i),
    .cfg_increment_i              (cfg_increment_i),
    .cfg_threshold_i              (cfg_threshold_i),
    .cfg_burst_len_i              (cfg_burst_len_i),
    .counter_value_o              (counter_value_o),
    .counter_value_valid_strobe_o (counter_value_valid_strobe_o),
    .threshold_o                  (threshold_o),
    .period_wrap_strobe_o         (period_wrap_strobe_o),
    .done_strobe_o                (done_strobe_o),
    .busy_o                       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    bit         wrap;
    logic [7:0] thr;
  } exp_t;

  exp_t exp_q[$];
  exp_t stage_q[$];
  int   done_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t mon_e;
  int   mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (counter_value_valid_strobe_o) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_strobe @cyc %0d: got value %0d, expected no strobe", cyc, counter_value_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_cycle", cyc, mon_e.cyc);
          check("counter_value", counter_value_o, mon_e.val);
          check("wrap_strobe", period_wrap_strobe_o, mon_e.wrap);
          check("threshold", threshold_o, mon_e.thr);
        end
      end else if (period_wrap_strobe_o) begin
        n_vec++; n_bad++;
        $display("FAIL wrap_without_strobe @cyc %0d: got 1, expected 0", cyc);
      end
      if (done_strobe_o) begin
        if (done_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_done @cyc %0d: got 1, expected 0", cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc, mon_d);
          check("busy_at_done", busy_o, 0);
        end
      end
    end
  end

  function automatic int tedge(input int s, input int p, input int k);
    return s + 1 + k * (p + 1);
  endfunction

  // Reference model: walks ticks k=1.. at their spec-defined edges and
  // applies the stop / burst / pending-config rules at each wrap.
  task automatic model_run(input int s, input int p, input int inc, input int thr, input int burst,
                           input bit do_cfg, input int jc, input int inc2, input int thr2, input int burst2,
                           input bit do_stop, input int js, input int lim,
                           output int t_end, output bit leftover);
    int  v, nv, wraps, a_inc, a_thr, a_burst, cfg_h, stop_e, t;
    bit  applied, w, fin;
    exp_t e;
    stage_q.delete();
    v = int'(SAMPLE_MIN); wraps = 0; applied = 0;
    a_inc = inc; a_thr = thr; a_burst = burst;
    cfg_h = tedge(s, p, jc) + 1;
    stop_e = tedge(s, p, js) + 1;
    t_end = -1;
    for (int k = 1; k <= lim; k++) begin
      t = tedge(s, p, k);
      nv = (v + a_inc) % 256;
      w = (v <= int'(SAMPLE_ONE)) && (nv >= int'(SAMPLE_MIN));
      fin = 0;
      if (w) begin
        fin = (do_stop && stop_e < t) || (a_burst != 0 && wraps + 1 == a_burst);
        wraps++;
        if (do_cfg && !applied && cfg_h < t) begin
          a_inc = inc2; a_thr = thr2; a_burst = burst2; applied = 1;
        end
      end
      e.cyc = t; e.val = nv[7:0]; e.wrap = w; e.thr = a_thr[7:0];
      stage_q.push_back(e);
      v = nv;
      if (fin) begin
        t_end = t;
        break;
      end
    end
    leftover = do_cfg && !applied && (t_end < 0 || cfg_h <= t_end);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic run_case(input bit prog, input int p, input int inc, input int thr, input int burst,
                          input bit do_cfg, input int jc, input int inc2, input int thr2, input int burst2,
                          input bit do_stop, input int js, input int cut_k);
    int s, t_end, r, last, cfg_c, stop_c, ign;
    bit left, run_cfg;
    if (prog) begin
      @(negedge clk);
      cfg_valid_i = 1'b1;
      cfg_prescale_i = 16'(p); cfg_increment_i = 7'(inc);
      cfg_threshold_i = 8'(thr); cfg_burst_len_i = 8'(burst);
      @(negedge clk);
      cfg_valid_i = 1'b0;
      check("idle_cfg_threshold", threshold_o, thr);
      check("idle_cfg_ready", cfg_ready_o, 1);
    end
    @(negedge clk);
    s = cyc;
    start_i = 1'b1;
    model_run(s, p, inc, thr, burst, do_cfg, jc, inc2, thr2, burst2, do_stop, js,
              (cut_k > 0) ? cut_k + 50 : 4000, t_end, left);
    r = (cut_k > 0) ? tedge(s, p, cut_k) + 1 : 32'h7fff_ffff;
    last = (cut_k > 0) ? r : t_end;
    if (last < 0) begin
      n_vec++; n_bad++;
      $display("FAIL model_no_end: got no end within budget, expected a finite run");
      last = s + 10;
    end
    foreach (stage_q[i]) if (stage_q[i].cyc < r) exp_q.push_back(stage_q[i]);
    if (t_end >= 0 && t_end + 1 < r) done_q.push_back(t_end + 1);
    cfg_c = tedge(s, p, jc);
    stop_c = tedge(s, p, js);
    run_cfg = do_cfg && (cfg_c + 1 < last);
    ign = s + (last - s) / 2;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc <= last + 3) begin
      stop_i = do_stop && (cyc == stop_c);
      cfg_valid_i = run_cfg && (cyc == cfg_c);
      cfg_prescale_i = 16'(p); cfg_increment_i = 7'(inc2);
      cfg_threshold_i = 8'(thr2); cfg_burst_len_i = 8'(burst2);
      start_i = (cyc == ign) && (ign >= s + 1) && (ign + 1 <= last - 1);
      rst_i = (cut_k > 0) && (cyc == r - 1);
      if (run_cfg && cyc == cfg_c + 1) check("pending_ready_low", cfg_ready_o, 0);
      @(negedge clk);
    end
    stop_i = 1'b0; cfg_valid_i = 1'b0; start_i = 1'b0; rst_i = 1'b0;
    check("busy_after_run", busy_o, 0);
    check("strobes_drained", exp_q.size(), 0);
    check("done_drained", done_q.size(), 0);
    exp_q.delete(); done_q.delete();
    if (cut_k > 0) begin
      check("reset_counter", counter_value_o, 0);
      check("reset_ready", cfg_ready_o, 1);
      check("reset_threshold", threshold_o, 0);
    end else if (left) begin
      pulse_reset();
      check("leftover_reset_ready", cfg_ready_o, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; cfg_valid_i = 1'b0;
    cfg_prescale_i = '0; cfg_increment_i = '0; cfg_threshold_i = '0; cfg_burst_len_i = '0;
    repeat (3) @(negedge clk);
    check("rst_counter", counter_value_o, 0);
    check("rst_strobe", counter_value_valid_strobe_o, 0);
    check("rst_threshold", threshold_o, 0);
    check("rst_wrap", period_wrap_strobe_o, 0);
    check("rst_done", done_strobe_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", cfg_ready_o, 1);
    rst_i = 1'b0;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_busy", busy_o, 0);

    // Burst of two periods at P=0, step 64.
    run_case(1, 0, 64, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0);
    // Prescaled continuous run ended by stop.
    run_case(1, 3, 32, 8'hF0, 0, 0, 1, 0, 0, 0, 1, 10, 0);
    // Mid-period reconfiguration offered at value 0.
    run_case(1, 0, 32, 0, 0, 1, 4, 64, 40, 0, 1, 10, 0);
    // Graceful stop at value 0.
    run_case(1, 0, 64, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0);
    // Reset mid-run with a pending config, then restart on defaults.
    run_case(1, 0, 32, 0, 0, 1, 2, 64, 40, 0, 0, 1, 5);
    run_case(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0);

    for (int n = 0; n < 16; n++) begin
      run_case(1, $urandom_range(0, 3), $urandom_range(8, 127), $urandom_range(0, 255),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(1, 20),
               $urandom_range(8, 127), $urandom_range(0, 255), $urandom_range(0, 3),
               1, $urandom_range(1, 40), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
